// File: rtl/two_ch_splitter.sv
// Two-channel frame splitter: hunts AAAA headers, routes each frame to the
// sink picked by the header select bit. Define SPLITTER_ERR_CNT_EN to build the error counters.
module two_ch_splitter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic                  CH0_FULL,
    input  logic                  CH1_FULL,
    output logic [DATA_WIDTH-1:0] CH0_DOUT,
    output logic [DATA_WIDTH-1:0] CH1_DOUT,
    output logic                  CH0_WE,
    output logic                  CH1_WE,
    output logic                  HDR_ERR,
    output logic                  FTR_ERR,
    output logic [15:0]           HDR_ERR_CNT,
    output logic [15:0]           FTR_ERR_CNT
);

    typedef enum logic {
        IDLE,
        ROUTE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DOUT_RST  = {16'h0000, {(DATA_WIDTH-16){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] LOST_FTR  = {{(DATA_WIDTH-16){1'b1}}, 16'h55EE};

    state_t                  state;
    logic                    sel;

    logic                    is_hdr;
    logic                    is_ftr;
    logic                    sel_full;
    logic                    hdr_cut;
    logic                    xfer;
    logic                    wr_en;
    logic                    wr_ch;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    hdr_err_nxt;
    state_t                  state_nxt;
    logic                    sel_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic hit);
        if (hit && cnt != 16'hFFFF)
            return cnt + 16'd1;
        return cnt;
    endfunction

    always_comb begin
        is_hdr   = (DIN[DATA_WIDTH-1 -: 16] == 16'hAAAA);
        is_ftr   = (DIN[15:0] == 16'h5555);
        sel_full = sel ? CH1_FULL : CH0_FULL;
        // A header arriving mid-frame is held off for one cycle while the lost footer is patched in.
        hdr_cut  = (state == ROUTE) && iVALID && is_hdr;

        oREADY = 1'b0;
        if (RESET_N) begin
            if (state == IDLE)
                oREADY = !CH0_FULL && !CH1_FULL;
            else
                oREADY = !sel_full && !hdr_cut;
        end
        xfer = iVALID && oREADY;
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_ch       = sel;
        wr_data     = DIN;
        hdr_err_nxt = 1'b0;
        state_nxt   = state;
        sel_nxt     = sel;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (is_hdr) begin
                        wr_en   = 1'b1;
                        wr_ch   = DIN[DATA_WIDTH-17];
                        sel_nxt = DIN[DATA_WIDTH-17];
                        if (!is_ftr)
                            state_nxt = ROUTE;
                    end else begin
                        hdr_err_nxt = 1'b1;
                    end
                end
            end
            ROUTE: begin
                if (hdr_cut) begin
                    wr_en     = 1'b1;
                    wr_data   = LOST_FTR;
                    state_nxt = IDLE;
                end else if (xfer) begin
                    wr_en = 1'b1;
                    if (is_ftr)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            sel      <= 1'b0;
            CH0_WE   <= 1'b0;
            CH1_WE   <= 1'b0;
            CH0_DOUT <= DOUT_RST;
            CH1_DOUT <= DOUT_RST;
            HDR_ERR  <= 1'b0;
            FTR_ERR  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            HDR_ERR <= hdr_err_nxt;
            FTR_ERR <= hdr_cut;
            CH0_WE  <= wr_en && !wr_ch;
            CH1_WE  <= wr_en && wr_ch;
            if (wr_en && !wr_ch)
                CH0_DOUT <= wr_data;
            if (wr_en && wr_ch)
                CH1_DOUT <= wr_data;
        end
    end

`ifdef SPLITTER_ERR_CNT_EN
    // Counters advance on the same edge that raises the matching pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HDR_ERR_CNT <= 16'h0000;
            FTR_ERR_CNT <= 16'h0000;
        end else begin
            HDR_ERR_CNT <= sat_inc(HDR_ERR_CNT, hdr_err_nxt);
            FTR_ERR_CNT <= sat_inc(FTR_ERR_CNT, hdr_cut);
        end
    end
`else
    assign HDR_ERR_CNT = 16'h0000;
    assign FTR_ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_two_ch_splitter.sv
// Scoreboard bench for two_ch_splitter: directed frames with hand-computed
// expected writes, error pulses and counter values.
module tb_two_ch_splitter;

    localparam int DW = 64;

    localparam logic [DW-1:0] H0   = 64'hAAAA_0123_4567_0000;
    localparam logic [DW-1:0] H1   = 64'hAAAA_8123_4567_0000;
    localparam logic [DW-1:0] H1W  = 64'hAAAA_0000_0000_5555;
    localparam logic [DW-1:0] B1   = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] B2   = 64'h5555_6666_7777_8888;
    localparam logic [DW-1:0] FT   = 64'h9999_0000_0000_5555;
    localparam logic [DW-1:0] INS  = 64'hFFFF_FFFF_FFFF_55EE;
    localparam logic [DW-1:0] DRST = 64'h0000_FFFF_FFFF_FFFF;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [DW-1:0] DIN;
    logic          iVALID;
    logic          oREADY;
    logic          CH0_FULL;
    logic          CH1_FULL;
    logic [DW-1:0] CH0_DOUT;
    logic [DW-1:0] CH1_DOUT;
    logic          CH0_WE;
    logic          CH1_WE;
    logic          HDR_ERR;
    logic          FTR_ERR;
    logic [15:0]   HDR_ERR_CNT;
    logic [15:0]   FTR_ERR_CNT;

    two_ch_splitter #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .iVALID(iVALID), .oREADY(oREADY),
        .CH0_FULL(CH0_FULL), .CH1_FULL(CH1_FULL),
        .CH0_DOUT(CH0_DOUT), .CH1_DOUT(CH1_DOUT), .CH0_WE(CH0_WE), .CH1_WE(CH1_WE),
        .HDR_ERR(HDR_ERR), .FTR_ERR(FTR_ERR),
        .HDR_ERR_CNT(HDR_ERR_CNT), .FTR_ERR_CNT(FTR_ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          ch;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   hdr_seen = 0;
    int   ftr_seen = 0;
    int   st       = 0;
    int   st_sum   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a write strobe is seen.
    always @(negedge CLK) begin
        if (HDR_ERR === 1'b1) hdr_seen++;
        if (FTR_ERR === 1'b1) ftr_seen++;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_write: got none expected ch%0d %h at cycle %0d", mon_e.ch, mon_e.data, mon_e.due);
        end
        if (CH0_WE === 1'b1 || CH1_WE === 1'b1) begin
            check("single_we", 64'(CH0_WE & CH1_WE), 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got ch0_we=%0b ch1_we=%0b expected no write", CH0_WE, CH1_WE);
            end else begin
                mon_e = sbq.pop_front();
                check("wr_channel", 64'(CH1_WE), 64'(mon_e.ch));
                check("wr_data", mon_e.ch ? CH1_DOUT : CH0_DOUT, mon_e.data);
                check("wr_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit wr, input logic ch,
                        input bit ins, input logic ins_ch, output int stalls);
        exp_t e;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        DIN    = w;
        iVALID = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (oREADY === 1'b1) begin
                done = 1'b1;
            end else begin
                if (ins && stalls == 0) begin
                    e.ch = ins_ch; e.data = INS; e.due = cyc + 1;
                    sbq.push_back(e);
                end
                stalls++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got oREADY=%0b expected 1 within 50 cycles", oREADY);
            iVALID = 1'b0;
            return;
        end
        if (wr) begin
            e.ch = ch; e.data = w; e.due = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
    endtask

    task automatic tx(input logic [DW-1:0] w, input bit wr, input logic ch);
        int s;
        send(w, wr, ch, 1'b0, 1'b0, s);
        st_sum += s;
    endtask

    task automatic drain();
        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N  = 1'b0;
        DIN      = '0;
        iVALID   = 1'b0;
        CH0_FULL = 1'b0;
        CH1_FULL = 1'b0;
        #12;
        check("rst_ch0_dout", CH0_DOUT, DRST);
        check("rst_ch1_dout", CH1_DOUT, DRST);
        check("rst_we", 64'({CH0_WE, CH1_WE}), 64'd0);
        check("rst_err", 64'({HDR_ERR, FTR_ERR}), 64'd0);
        check("rst_ready", 64'(oREADY), 64'd0);
        check("rst_cnt", 64'({HDR_ERR_CNT, FTR_ERR_CNT}), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Plain frame to CH0, no stalls.
        st_sum = 0;
        tx(H0, 1, 0); tx(B1, 1, 0); tx(B2, 1, 0); tx(FT, 1, 0);
        check("ch0_frame_stalls", 64'(st_sum), 64'd0);
        drain();

        // CH1 frame then CH0 frame back-to-back, then one-word frame followed by a frame.
        st_sum = 0;
        tx(H1, 1, 1); tx(B1, 1, 1); tx(FT, 1, 1);
        tx(H0, 1, 0); tx(B2, 1, 0); tx(FT, 1, 0);
        tx(H1W, 1, 0);
        tx(H1, 1, 1); tx(FT, 1, 1);
        check("b2b_stalls", 64'(st_sum), 64'd0);
        drain();
        check("b2b_no_errors", 64'(hdr_seen + ftr_seen), 64'd0);

        // Lost footer: a new header cuts the CH0 frame short.
        tx(H0, 1, 0); tx(B1, 1, 0);
        send(H1, 1, 1, 1, 0, st);
        check("lost_ftr_stall", 64'(st), 64'd1);
        tx(B2, 1, 1); tx(FT, 1, 1);
        drain();
        check("lost_ftr_pulses", 64'(ftr_seen), 64'd1);

        // Garbage in IDLE is discarded with one HDR_ERR each.
        tx(B1, 0, 0); tx(FT, 0, 0); tx(B2, 0, 0);
        tx(H0, 1, 0); tx(B1, 1, 0); tx(FT, 1, 0);
        drain();
        check("garbage_hdr_pulses", 64'(hdr_seen), 64'd3);

        // IDLE readiness needs both sinks free.
        CH0_FULL = 1'b1;
        @(negedge CLK);
        check("idle_ready_ch0_full", 64'(oREADY), 64'd0);
        CH0_FULL = 1'b0;
        @(negedge CLK);
        check("idle_ready_free", 64'(oREADY), 64'd1);
        @(posedge CLK);
        #1;

        // CH1 backpressure mid-frame for 5 cycles.
        tx(H1, 1, 1); tx(B1, 1, 1);
        CH1_FULL = 1'b1;
        fork
            begin
                repeat (5) @(posedge CLK);
                #1;
                CH1_FULL = 1'b0;
            end
        join_none
        send(B2, 1, 1, 0, 0, st);
        check("full_stall_cycles", 64'(st), 64'd5);
        tx(FT, 1, 1);
        drain();

`ifdef SPLITTER_ERR_CNT_EN
        check("hdr_cnt", 64'(HDR_ERR_CNT), 64'd3);
        check("ftr_cnt", 64'(FTR_ERR_CNT), 64'd1);
`else
        check("hdr_cnt", 64'(HDR_ERR_CNT), 64'd0);
        check("ftr_cnt", 64'(FTR_ERR_CNT), 64'd0);
`endif

        // Reset mid-frame, then a stray body word is rejected.
        tx(H0, 1, 0); tx(B1, 1, 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check("midrst_ch0_dout", CH0_DOUT, DRST);
        check("midrst_ch1_dout", CH1_DOUT, DRST);
        check("midrst_ready", 64'(oREADY), 64'd0);
        check("midrst_cnt", 64'({HDR_ERR_CNT, FTR_ERR_CNT}), 64'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        tx(B2, 0, 0);
        tx(H0, 1, 0); tx(B1, 1, 0); tx(FT, 1, 0);
        drain();
        check("post_rst_hdr_pulses", 64'(hdr_seen), 64'd4);
        check("post_rst_ftr_pulses", 64'(ftr_seen), 64'd1);
`ifdef SPLITTER_ERR_CNT_EN
        check("post_rst_hdr_cnt", 64'(HDR_ERR_CNT), 64'd1);
`else
        check("post_rst_hdr_cnt", 64'(HDR_ERR_CNT), 64'd0);
`endif
        check("post_rst_ftr_cnt", 64'(FTR_ERR_CNT), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
